// File: rtl/led_pwm_driver.sv
// LED brightness/blink driver: PWM-gates a shadowed LED word, reloading the
// shadows only at PWM period boundaries so the pins never glitch mid-period.
module led_pwm_driver #(
    parameter int unsigned NUM_LEDS      = 8,
    parameter int unsigned PRESCALE      = 50,
    parameter int unsigned PWM_BITS      = 4,
    parameter int unsigned BLINK_PERIODS = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] led_in,
    input  logic [PWM_BITS:0]   duty,
    input  logic                blink_en,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                period_start
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned BL_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_PERIODS - 1);

    logic [PS_W-1:0]     r_presc_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [BL_W-1:0]     r_blink_cnt;
    logic                r_blink_phase;
    logic [NUM_LEDS-1:0] r_led_shadow;
    logic [PWM_BITS:0]   r_duty_shadow;
    logic                r_blink_shadow;
    logic                r_load_pending;

    logic w_tick;
    logic w_period_wrap;
    logic w_load;
    logic w_on;

    always_comb begin
        w_tick        = (r_presc_cnt == PS_LAST);
        w_period_wrap = w_tick && (r_pwm_cnt == '1);
        w_load        = r_load_pending | w_period_wrap;
        // duty is one bit wider than the counter so 2^PWM_BITS and above mean always-on
        w_on          = ({1'b0, r_pwm_cnt} < r_duty_shadow) && !(r_blink_shadow && r_blink_phase);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc_cnt    <= '0;
            r_pwm_cnt      <= '0;
            r_blink_cnt    <= '0;
            r_blink_phase  <= 1'b0;
            r_led_shadow   <= '0;
            r_duty_shadow  <= '0;
            r_blink_shadow <= 1'b0;
            r_load_pending <= 1'b1;
            led_out        <= '0;
            period_start   <= 1'b0;
        end else begin
            r_presc_cnt <= w_tick ? '0 : r_presc_cnt + 1'b1;

            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end

            if (w_period_wrap) begin
                if (r_blink_cnt == BL_LAST) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end

            if (w_load) begin
                r_led_shadow   <= led_in;
                r_duty_shadow  <= duty;
                r_blink_shadow <= blink_en;
                r_load_pending <= 1'b0;
            end

            period_start <= w_load;
            led_out      <= r_led_shadow & {NUM_LEDS{w_on}};
        end
    end

endmodule
